// File: rtl/alu_forward_unit.sv
// alu_forward_unit: execute-stage operand generator with private MEM/WB shadow slots,
// RAW forwarding (MEM over WB, r0 never forwarded), ALU-source select and a saturating event counter.
`default_nettype none

module alu_forward_unit #(
    parameter int NBITS = 32,
    parameter int RBITS = 5,
    parameter int CBITS = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_flush,
    input  logic [RBITS-1:0] i_rs,
    input  logic [RBITS-1:0] i_rt,
    input  logic [NBITS-1:0] i_rs_data,
    input  logic [NBITS-1:0] i_rt_data,
    input  logic [NBITS-1:0] i_immediate,
    input  logic             i_alu_source,
    input  logic [RBITS-1:0] i_ex_rd,
    input  logic             i_ex_regwrite,
    input  logic             i_ex_memread,
    input  logic [NBITS-1:0] i_ex_result,
    input  logic [NBITS-1:0] i_mem_rdata,
    output logic [NBITS-1:0] o_aluinA,
    output logic [NBITS-1:0] o_aluinB,
    output logic [NBITS-1:0] o_store_data,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [CBITS-1:0] o_fwd_count
);

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    logic [RBITS-1:0] mem_rd;
    logic             mem_regwrite;
    logic             mem_memread;
    logic [NBITS-1:0] mem_result;
    logic [RBITS-1:0] wb_rd;
    logic             wb_regwrite;
    logic [NBITS-1:0] wb_value;
    logic [CBITS-1:0] fwd_count;

    logic [NBITS-1:0] mem_value;
    logic             mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
    logic [1:0]       fwd_a, fwd_b;
    logic [NBITS-1:0] rs_value, rt_value;

    // A load in MEM forwards the live memory read data, not its address.
    assign mem_value = mem_memread ? i_mem_rdata : mem_result;

    assign mem_hit_rs = mem_regwrite && (mem_rd != '0) && (mem_rd == i_rs);
    assign mem_hit_rt = mem_regwrite && (mem_rd != '0) && (mem_rd == i_rt);
    assign wb_hit_rs  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == i_rs);
    assign wb_hit_rt  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == i_rt);

    always_comb begin
        fwd_a    = FWD_NONE;
        fwd_b    = FWD_NONE;
        rs_value = i_rs_data;
        rt_value = i_rt_data;
        if (mem_hit_rs) begin
            fwd_a    = FWD_MEM;
            rs_value = mem_value;
        end else if (wb_hit_rs) begin
            fwd_a    = FWD_WB;
            rs_value = wb_value;
        end
        if (mem_hit_rt) begin
            fwd_b    = FWD_MEM;
            rt_value = mem_value;
        end else if (wb_hit_rt) begin
            fwd_b    = FWD_WB;
            rt_value = wb_value;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_result   <= '0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            wb_value     <= '0;
            fwd_count    <= '0;
        end else if (i_enable) begin
            mem_rd       <= i_ex_rd;
            mem_regwrite <= i_ex_regwrite & ~i_flush;
            mem_memread  <= i_ex_memread & ~i_flush;
            mem_result   <= i_ex_result;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
            wb_value     <= mem_value;
            if (((fwd_a != FWD_NONE) || (fwd_b != FWD_NONE)) && (fwd_count != {CBITS{1'b1}}))
                fwd_count <= fwd_count + 1'b1;
        end
    end

    assign o_aluinA     = rs_value;
    assign o_store_data = rt_value;
    assign o_aluinB     = i_alu_source ? i_immediate : rt_value;
    assign o_fwd_a      = fwd_a;
    assign o_fwd_b      = fwd_b;
    assign o_fwd_count  = fwd_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_forward_unit.sv
// Scoreboard bench for alu_forward_unit (CBITS=2 so counter saturation is reachable).
`default_nettype none

module tb_alu_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b1;
    logic        flush = 1'b0;
    logic [4:0]  rs = '0, rt = '0, ex_rd = '0;
    logic [31:0] rs_data = '0, rt_data = '0, immediate = '0, ex_result = '0, mem_rdata = '0;
    logic        alu_source = 1'b0, ex_regwrite = 1'b0, ex_memread = 1'b0;
    logic [31:0] aluinA, aluinB, store_data;
    logic [1:0]  fwd_a, fwd_b;
    logic [1:0]  fwd_count;

    typedef struct {
        string       tag;
        logic [31:0] a, b, st;
        logic [1:0]  fa, fb, cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    alu_forward_unit #(.NBITS(32), .RBITS(5), .CBITS(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_flush(flush),
        .i_rs(rs), .i_rt(rt), .i_rs_data(rs_data), .i_rt_data(rt_data),
        .i_immediate(immediate), .i_alu_source(alu_source),
        .i_ex_rd(ex_rd), .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread),
        .i_ex_result(ex_result), .i_mem_rdata(mem_rdata),
        .o_aluinA(aluinA), .o_aluinB(aluinB), .o_store_data(store_data),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_fwd_count(fwd_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] st, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [1:0] cnt);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.st = st; e.fa = fa; e.fb = fb; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Compare on the falling edge, then let one rising edge consume the driven inputs.
    task automatic sample_and_tick();
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val({e.tag, ".aluinA"}, aluinA, e.a);
            check_val({e.tag, ".aluinB"}, aluinB, e.b);
            check_val({e.tag, ".store"},  store_data, e.st);
            check_val({e.tag, ".fwd_a"},  {30'd0, fwd_a}, {30'd0, e.fa});
            check_val({e.tag, ".fwd_b"},  {30'd0, fwd_b}, {30'd0, e.fb});
            check_val({e.tag, ".count"},  {30'd0, fwd_count}, {30'd0, e.cnt});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [4:0] rd, input logic rw, input logic mr, input logic [31:0] res);
        ex_rd = rd; ex_regwrite = rw; ex_memread = mr; ex_result = res;
    endtask

    task automatic set_src(input logic [4:0] s, input logic [31:0] sd, input logic [4:0] t,
                           input logic [31:0] td, input logic asrc, input logic [31:0] imm);
        rs = s; rs_data = sd; rt = t; rt_data = td; alu_source = asrc; immediate = imm;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        set_src(5'd1, 32'h5, 5'd2, 32'h77, 1'b1, 32'h9);
        push_exp("reset", 32'h5, 32'h9, 32'h77, 2'b00, 2'b00, 2'd0);
        sample_and_tick();
        rst_n = 1'b1;

        // Producer r3=0x10 enters EX; nothing to forward yet.
        set_ex(5'd3, 1'b1, 1'b0, 32'h10);
        push_exp("first", 32'h5, 32'h9, 32'h77, 2'b00, 2'b00, 2'd0);
        sample_and_tick();

        set_src(5'd3, 32'h0, 5'd2, 32'h77, 1'b0, 32'h9);
        set_ex(5'd3, 1'b1, 1'b0, 32'h20);
        push_exp("mem_fwd", 32'h10, 32'h77, 32'h77, 2'b10, 2'b00, 2'd0);
        sample_and_tick();

        set_src(5'd3, 32'h0, 5'd3, 32'h0, 1'b0, 32'h9);
        set_ex(5'd0, 1'b0, 1'b0, 32'h0);
        push_exp("mem_prio", 32'h20, 32'h20, 32'h20, 2'b10, 2'b10, 2'd1);
        sample_and_tick();

        set_ex(5'd4, 1'b1, 1'b1, 32'h999);
        push_exp("wb_fwd", 32'h20, 32'h20, 32'h20, 2'b01, 2'b01, 2'd2);
        sample_and_tick();

        // Load to r4 now in MEM: its data comes from the live memory read port.
        set_src(5'd5, 32'h55, 5'd4, 32'h1, 1'b1, 32'h9);
        mem_rdata = 32'hABCD;
        set_ex(5'd0, 1'b1, 1'b0, 32'h7);
        push_exp("load_mem", 32'h55, 32'h9, 32'hABCD, 2'b00, 2'b10, 2'd3);
        sample_and_tick();

        set_src(5'd0, 32'h11, 5'd4, 32'h1, 1'b0, 32'h9);
        mem_rdata = 32'hDEAD;
        set_ex(5'd4, 1'b1, 1'b0, 32'h66);
        push_exp("r0_sat", 32'h11, 32'hABCD, 32'hABCD, 2'b00, 2'b01, 2'd3);
        sample_and_tick();

        // Asynchronous reset with r4 pending in MEM.
        rst_n = 1'b0;
        set_src(5'd4, 32'h44, 5'd4, 32'h45, 1'b0, 32'h9);
        set_ex(5'd0, 1'b0, 1'b0, 32'h0);
        push_exp("mid_reset", 32'h44, 32'h45, 32'h45, 2'b00, 2'b00, 2'd0);
        sample_and_tick();
        rst_n = 1'b1;

        set_src(5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'h9);
        set_ex(5'd6, 1'b1, 1'b0, 32'h60);
        push_exp("post_reset", 32'h1, 32'h2, 32'h2, 2'b00, 2'b00, 2'd0);
        sample_and_tick();

        enable = 1'b0;
        flush = 1'b1;
        set_src(5'd6, 32'h0, 5'd2, 32'h2, 1'b0, 32'h9);
        set_ex(5'd7, 1'b1, 1'b0, 32'h70);
        for (int i = 0; i < 3; i++) begin
            push_exp($sformatf("stall%0d", i), 32'h60, 32'h2, 32'h2, 2'b10, 2'b00, 2'd0);
            sample_and_tick();
        end

        enable = 1'b1;
        set_ex(5'd5, 1'b1, 1'b0, 32'h50);
        push_exp("flush_edge", 32'h60, 32'h2, 32'h2, 2'b10, 2'b00, 2'd0);
        sample_and_tick();
        flush = 1'b0;

        set_src(5'd5, 32'h5a, 5'd6, 32'h0, 1'b1, 32'h123);
        set_ex(5'd0, 1'b0, 1'b0, 32'h0);
        push_exp("flushed_mem", 32'h5a, 32'h123, 32'h60, 2'b00, 2'b01, 2'd1);
        sample_and_tick();

        set_src(5'd5, 32'h5a, 5'd6, 32'h6b, 1'b0, 32'h123);
        push_exp("flushed_wb", 32'h5a, 32'h6b, 32'h6b, 2'b00, 2'b00, 2'd2);
        sample_and_tick();

        check_val("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_forward_unit.md
# alu_forward_unit

Execute-stage operand generator for the pipelined MIPS core: it keeps its own shadow copies of the EX/MEM and MEM/WB write-back information and resolves RAW hazards by forwarding. It then applies the ALU-source selection, delivering final ALU operands A and B plus the forwarded store data. It sits directly ahead of the ALU. It drives the operand selection that the ALU-source mux consumes, and exports the select codes and a forwarding-event counter for the debug unit.

## Interface
- NBITS, 32, datapath width
- RBITS, 5, register-address width
- CBITS, 16, forwarding-event counter width
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  pipeline advance; 0 = stall, all state holds
- i_flush  in  1  insert bubble into MEM slot (sampled only when i_enable=1)
- i_rs, i_rt  in  RBITS  source register addresses of instruction in EX
- i_rs_data, i_rt_data  in  NBITS  register-file read data for rs/rt
- i_immediate  in  NBITS  sign/zero-extended immediate
- i_alu_source  in  1  0 = operand B from rt, 1 = operand B from immediate
- i_ex_rd  in  RBITS  destination register of instruction in EX
- i_ex_regwrite, i_ex_memread  in  1  EX instruction writes a register / is a load
- i_ex_result  in  NBITS  ALU result of instruction in EX
- i_mem_rdata  in  NBITS  data-memory read data of instruction in MEM (combinationally valid)
- o_aluinA, o_aluinB  out  NBITS  final ALU operands
- o_store_data  out  NBITS  forwarded rt value (for stores)
- o_fwd_a, o_fwd_b  out  2  00 none, 01 from WB slot, 10 from MEM slot
- o_fwd_count  out  CBITS  saturating count of forwarding cycles

## Operation
- State: MEM slot {mem_rd, mem_regwrite, mem_memread, mem_result}, WB slot {wb_rd, wb_regwrite, wb_value}, counter.
- On rising edge with i_enable=1:
  - MEM slot <= {i_ex_rd, i_ex_regwrite & ~i_flush, i_ex_memread & ~i_flush, i_ex_result}.
  - WB slot <= {mem_rd, mem_regwrite, mem_memread ? i_mem_rdata : mem_result}.
- With i_enable=0: both slots and the counter hold. i_flush is ignored.
- MEM match for X in {rs, rt}: mem_regwrite & (mem_rd != 0) & (mem_rd == X).
- WB match: same condition using the wb_* fields.
- Forwarding priority: MEM match → 10, else WB match → 01, else 00. Register 0 is never forwarded.
- MEM forwarded value = mem_memread ? i_mem_rdata : mem_result. WB forwarded value = wb_value. Code 00 uses i_rs_data / i_rt_data.
- o_aluinA = forwarded rs. o_store_data = forwarded rt.
- o_aluinB = i_alu_source ? i_immediate : forwarded rt. o_fwd_b still reports the rt resolution when i_alu_source=1.
- Counter: increments on an enabled edge when o_fwd_a != 00 or o_fwd_b != 00. It saturates at 2^CBITS-1 and does not wrap.
- Operand outputs are combinational from the inputs and current slot state. There is no path from i_ex_result to any output in the same cycle, so there is no combinational loop through the ALU.

## Timing
- Reset (asynchronous, immediate on i_rst_n=0): all slot fields and o_fwd_count cleared to 0.
  - Consequence: o_fwd_a = o_fwd_b = 00, o_aluinA = i_rs_data, o_store_data = i_rt_data, o_aluinB = i_alu_source ? i_immediate : i_rt_data.
- Latency: a result produced in EX at edge N is forwardable from the MEM slot in cycle N+1 and from the WB slot in cycle N+2. After that it comes from the register file.
- Stall: outputs keep following the held slots, so a stalled EX instruction sees stable forwarding.
- Both slots match the same register: MEM wins (youngest producer).
- Load in MEM slot: i_mem_rdata is forwarded. The load value carried into the WB slot is i_mem_rdata as sampled at the advancing edge.
- Reset deassertion mid-pipeline: the first instruction after reset sees no forwarding.

## Test plan
- Reset: i_rst_n=0, i_rs=1, i_rs_data=5, i_alu_source=1, i_immediate=9 → o_aluinA=5, o_aluinB=9, o_fwd_a=o_fwd_b=00, o_fwd_count=0.
- MEM forward: edge with i_ex_rd=3, i_ex_regwrite=1, i_ex_result=0x10. Next cycle i_rs=3, i_rs_data=0 → o_fwd_a=10, o_aluinA=0x10.
- Priority plus WB forward: producers writing r3 = 0x10 then r3 = 0x20 on consecutive edges, then i_rs=i_rt=3, i_alu_source=0 → o_aluinA=o_aluinB=0x20, fwd=10. One more enabled edge with a non-writing EX instruction → fwd=01, value 0x20.
- Load and r0: load to r4 (i_ex_memread=1), next cycle i_mem_rdata=0xABCD, i_rt=4 → o_store_data=0xABCD, o_fwd_b=10. Producer writing r0 = 7 → no forwarding when i_rs=0.
- Stall/flush: i_enable=0 for 3 edges → MEM forward persists and o_fwd_count does not increment. An edge with i_flush=1 and i_ex_regwrite=1, i_ex_rd=5 → no forward for r5 next cycle.
- Counter saturation with CBITS=2: 5 consecutive forwarding cycles → o_fwd_count=3.
